// File: rtl/upload_packer_pkg.sv
// upload_packer shared definitions.
// Frame header bytes, channel state encoding and checksum helper.
package upload_packer_pkg;

  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h44;
  localparam int FRAME_OVERHEAD = 6;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_COLLECT   = 4'd1,
    ST_SEND_H0   = 4'd2,
    ST_SEND_H1   = 4'd3,
    ST_SEND_SRC  = 4'd4,
    ST_SEND_LENH = 4'd5,
    ST_SEND_LENL = 4'd6,
    ST_SEND_DATA = 4'd7,
    ST_SEND_CKSUM = 4'd8
  } state_e;

  function automatic logic [7:0] cksum_f(
    input logic [7:0]  dsum,
    input logic [7:0]  src,
    input logic [15:0] len
  );
    return dsum + src + len[15:8] + len[7:0];
  endfunction

endpackage

// File: rtl/upload_packer_channel.sv
// One upload channel: burst buffer plus framing FSM.
// All outputs are registered; buffer is a plain RAM array.
module upload_packer_channel
  import upload_packer_pkg::*;
#(
  parameter int MAX_DATA_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [7:0] data_i,
  input  logic [7:0] src_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       preq_o,
  output logic [7:0] pdata_o,
  output logic [7:0] psrc_o,
  output logic       pvalid_o,
  input  logic       pready_i
);

  localparam int AW = $clog2(MAX_DATA_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_DATA_LEN);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx_q;
  logic [7:0]    sum_q;
  logic [7:0]    src_q;
  logic          rdy_q;
  logic          preq_q;
  logic          pvld_q;
  logic [7:0]    pdat_q;
  logic [7:0]    psrc_q;
  logic [7:0]    mem_q [MAX_DATA_LEN];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] cnt_d;
  logic [15:0]   len;
  logic [7:0]    rd_data;
  logic          adv;

  assign len     = 16'(cnt_q);
  assign rd_data = mem_q[idx_q[AW-1:0]];
  assign adv     = pvld_q & pready_i;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q[AW-1:0];
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        wr_en   = req_i & valid_i & rdy_q;
        wr_addr = '0;
        cnt_d   = CW'(wr_en);
      end
      ST_COLLECT: begin
        wr_en = req_i & valid_i & rdy_q;
        cnt_d = cnt_q + CW'(wr_en);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      src_q   <= '0;
      rdy_q   <= 1'b0;
      preq_q  <= 1'b0;
      pvld_q  <= 1'b0;
      pdat_q  <= '0;
      psrc_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (req_i) begin
            state_q <= ST_COLLECT;
            src_q   <= src_i;
            cnt_q   <= cnt_d;
            sum_q   <= wr_en ? data_i : 8'h00;
            rdy_q   <= cnt_d < MaxCnt;
          end
        end
        ST_COLLECT: begin
          if (!req_i) begin
            idx_q <= '0;
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= ST_SEND_H0;
              rdy_q   <= 1'b0;
              preq_q  <= 1'b1;
              pvld_q  <= 1'b1;
              pdat_q  <= HDR0;
              psrc_q  <= src_q;
            end
          end else begin
            cnt_q <= cnt_d;
            rdy_q <= cnt_d < MaxCnt;
            if (wr_en) sum_q <= sum_q + data_i;
          end
        end
        ST_SEND_H0: if (adv) begin
          state_q <= ST_SEND_H1;
          pdat_q  <= HDR1;
        end
        ST_SEND_H1: if (adv) begin
          state_q <= ST_SEND_SRC;
          pdat_q  <= src_q;
        end
        ST_SEND_SRC: if (adv) begin
          state_q <= ST_SEND_LENH;
          pdat_q  <= len[15:8];
        end
        ST_SEND_LENH: if (adv) begin
          state_q <= ST_SEND_LENL;
          pdat_q  <= len[7:0];
        end
        ST_SEND_LENL: if (adv) begin
          state_q <= ST_SEND_DATA;
          pdat_q  <= rd_data;
          idx_q   <= idx_q + 1'b1;
        end
        ST_SEND_DATA: if (adv) begin
          // idx_q runs one ahead of the byte on the bus
          if (idx_q == cnt_q) begin
            state_q <= ST_SEND_CKSUM;
            pdat_q  <= cksum_f(sum_q, src_q, len);
          end else begin
            pdat_q <= rd_data;
            idx_q  <= idx_q + 1'b1;
          end
        end
        ST_SEND_CKSUM: if (adv) begin
          state_q <= ST_IDLE;
          preq_q  <= 1'b0;
          pvld_q  <= 1'b0;
          pdat_q  <= '0;
          psrc_q  <= '0;
          rdy_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = rdy_q;
  assign preq_o   = preq_q;
  assign pvalid_o = pvld_q;
  assign pdata_o  = pdat_q;
  assign psrc_o   = psrc_q;

endmodule

// File: rtl/upload_packer.sv
// Multi-channel upload frame packer.
// Independent channels, flat buses sliced per channel.
module upload_packer
  import upload_packer_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int MAX_DATA_LEN = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CHANNELS-1:0]   raw_upload_req,
  input  logic [NUM_CHANNELS*8-1:0] raw_upload_data,
  input  logic [NUM_CHANNELS*8-1:0] raw_upload_source,
  input  logic [NUM_CHANNELS-1:0]   raw_upload_valid,
  output logic [NUM_CHANNELS-1:0]   raw_upload_ready,
  output logic [NUM_CHANNELS-1:0]   packed_upload_req,
  output logic [NUM_CHANNELS*8-1:0] packed_upload_data,
  output logic [NUM_CHANNELS*8-1:0] packed_upload_source,
  output logic [NUM_CHANNELS-1:0]   packed_upload_valid,
  input  logic [NUM_CHANNELS-1:0]   packed_upload_ready
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    upload_packer_channel #(
      .MAX_DATA_LEN(MAX_DATA_LEN)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (raw_upload_req[i]),
      .data_i   (raw_upload_data[8*i +: 8]),
      .src_i    (raw_upload_source[8*i +: 8]),
      .valid_i  (raw_upload_valid[i]),
      .ready_o  (raw_upload_ready[i]),
      .preq_o   (packed_upload_req[i]),
      .pdata_o  (packed_upload_data[8*i +: 8]),
      .psrc_o   (packed_upload_source[8*i +: 8]),
      .pvalid_o (packed_upload_valid[i]),
      .pready_i (packed_upload_ready[i])
    );
  end

endmodule

// File: tb/tb_upload_packer.sv
// Bench for upload_packer: directed bursts, scoreboard
// queues per channel, negedge monitors.
module tb_upload_packer;

  localparam int MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, valid, rdy, preq, pvld, pready;
  logic [15:0] data, src, pdata, psrc;

  int nvec = 0;
  int nerr = 0;
  bit bp = 1'b0;

  logic [7:0] b0 [80];
  logic [7:0] b1 [80];
  int n0, n1;
  logic [7:0] s0, s1;

  always #5 clk = ~clk;

  upload_packer #(
    .NUM_CHANNELS(2),
    .MAX_DATA_LEN(MAX)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .raw_upload_req      (req),
    .raw_upload_data     (data),
    .raw_upload_source   (src),
    .raw_upload_valid    (valid),
    .raw_upload_ready    (rdy),
    .packed_upload_req   (preq),
    .packed_upload_data  (pdata),
    .packed_upload_source(psrc),
    .packed_upload_valid (pvld),
    .packed_upload_ready (pready)
  );

  initial begin
    pready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      pready = bp ? ~pready : 2'b11;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_mon
    logic [7:0] q[$];
    logic [7:0] esrc;
    logic [7:0] hold;
    logic [7:0] exp;
    bit stall;
    initial begin
      stall = 1'b0;
      esrc  = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          stall = 1'b0;
        end else begin
          if (stall) begin
            nvec++;
            assert (pvld[c] === 1'b1 &&
                    pdata[8*c +: 8] === hold)
            else begin
              nerr++;
              $error("FAIL hold ch%0d got %h/%b want %h/1",
                     c, pdata[8*c +: 8], pvld[c], hold);
            end
          end
          if (pvld[c] && pready[c]) begin
            stall = 1'b0;
            nvec++;
            assert (q.size() > 0)
            else begin
              nerr++;
              $error("FAIL extra ch%0d got %h want none",
                     c, pdata[8*c +: 8]);
            end
            if (q.size() > 0) begin
              exp = q.pop_front();
              nvec++;
              assert ({preq[c], psrc[8*c +: 8],
                       pdata[8*c +: 8]} ===
                      {1'b1, esrc, exp})
              else begin
                nerr++;
                $error("FAIL byte ch%0d got %b/%h/%h want 1/%h/%h",
                       c, preq[c], psrc[8*c +: 8],
                       pdata[8*c +: 8], esrc, exp);
              end
            end
          end else begin
            stall = pvld[c];
            hold  = pdata[8*c +: 8];
          end
        end
      end
    end
  end

  task automatic push_frame(input int c,
                            input logic [7:0] s,
                            input int n);
    logic [7:0] f[$];
    logic [7:0] d;
    logic [7:0] ck;
    int m;
    m  = (n > MAX) ? MAX : n;
    ck = s + 8'(m >> 8) + 8'(m);
    f.push_back(8'hAA);
    f.push_back(8'h44);
    f.push_back(s);
    f.push_back(8'(m >> 8));
    f.push_back(8'(m));
    for (int i = 0; i < m; i++) begin
      d = (c == 0) ? b0[i] : b1[i];
      f.push_back(d);
      ck = ck + d;
    end
    f.push_back(ck);
    if (c == 0) begin
      g_mon[0].q    = f;
      g_mon[0].esrc = s;
    end else begin
      g_mon[1].q    = f;
      g_mon[1].esrc = s;
    end
  endtask

  task automatic collect(input bit e0, input bit e1);
    int mx;
    mx = 0;
    if (e0 && n0 > mx) mx = n0;
    if (e1 && n1 > mx) mx = n1;
    @(posedge clk);
    #1;
    req = {e1, e0};
    src = {s1, s0};
    for (int k = 0; k < mx; k++) begin
      valid[0] = e0 && (k < n0);
      valid[1] = e1 && (k < n1);
      data[7:0]  = (k < n0) ? b0[k] : 8'h00;
      data[15:8] = (k < n1) ? b1[k] : 8'h00;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (valid[c]) begin
          nvec++;
          assert (rdy[c] === (k < MAX))
          else begin
            nerr++;
            $error("FAIL raw_rdy ch%0d k=%0d got %b want %b",
                   c, k, rdy[c], (k < MAX));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    req   = 2'b00;
    valid = 2'b00;
    if (e0) push_frame(0, s0, n0);
    if (e1) push_frame(1, s1, n1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((g_mon[0].q.size() > 0 ||
            g_mon[1].q.size() > 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    nvec++;
    assert (t < 500)
    else begin
      nerr++;
      $error("FAIL %s timeout left %0d/%0d want 0/0",
             tag, g_mon[0].q.size(), g_mon[1].q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    assert ({pvld, preq, rdy} === 6'b00_00_11)
    else begin
      nerr++;
      $error("FAIL %s end got v%b r%b rdy%b want 00/00/11",
             tag, pvld, preq, rdy);
    end
  endtask

  task automatic test1;
    s0 = 8'h01;
    b0[0] = 8'hA1; b0[1] = 8'hA2; b0[2] = 8'hA3;
    n0 = 3;
    collect(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    valid = '0;
    data  = '0;
    src   = '0;
    n0 = 0; n1 = 0; s0 = '0; s1 = '0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    assert ({rdy, preq, pvld, pdata, psrc} === '0)
    else begin
      nerr++;
      $error("FAIL reset got %b %b %b %h %h want 0",
             rdy, preq, pvld, pdata, psrc);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    assert (rdy === 2'b11)
    else begin
      nerr++;
      $error("FAIL idle_rdy got %b want 11", rdy);
    end

    test1();
    drain("t1");

    s1 = 8'h03;
    b1[0] = 8'hB1; b1[1] = 8'hB2; b1[2] = 8'hB3;
    n1 = 3;
    collect(1'b0, 1'b1);
    drain("t2");

    b0[0] = 8'hC0; b0[1] = 8'hC1; n0 = 2;
    b1[0] = 8'hD0; b1[1] = 8'hD1; n1 = 2;
    collect(1'b1, 1'b1);
    drain("t3");

    bp = 1'b1;
    test1();
    drain("t4");
    bp = 1'b0;

    @(posedge clk);
    #1;
    req = 2'b01;
    @(posedge clk);
    #1;
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      assert (pvld === 2'b00 && preq === 2'b00)
      else begin
        nerr++;
        $error("FAIL empty got v%b r%b want 00/00",
               pvld, preq);
      end
    end
    nvec++;
    assert (rdy === 2'b11)
    else begin
      nerr++;
      $error("FAIL empty_rdy got %b want 11", rdy);
    end

    s0 = 8'h5A;
    for (int i = 0; i < MAX + 2; i++) b0[i] = 8'(i * 3 + 7);
    n0 = MAX + 2;
    collect(1'b1, 1'b0);
    drain("t6full");

    collect(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    assert ({rdy, preq, pvld, pdata, psrc} === '0)
    else begin
      nerr++;
      $error("FAIL midrst got %b %b %b %h %h want 0",
             rdy, preq, pvld, pdata, psrc);
    end
    g_mon[0].q.delete();
    g_mon[1].q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    test1();
    drain("t6rec");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
